// File: rtl/a_mux_trace_64x64.sv
// a_mux_trace_64x64: return-path result capture for the emulation trace path.
// Captures DUT results qualified by dut_dv_i into a small first-word-fall-through
// FIFO and hands them to the trace controller over a req/ack handshake.
// Counts captured results per session and pulses done_o at session end.
// Optional build macro: TRACE_OVF_CNT_EN enables the dropped-result counter
// on ovf_cnt_o; without it ovf_cnt_o is tied to zero (ovf_o still works).
module a_mux_trace_64x64 #(
  parameter int unsigned DATA_W     = 64,
  parameter int unsigned DEPTH_LOG2 = 3,
  parameter int unsigned CNT_W      = 16
) (
  input  logic              clk_ref,
  input  logic              rst_n,
  input  logic              run_i,
  input  logic              stop_i,
  input  logic [CNT_W-1:0]  nb_trace_i,
  input  logic              dut_dv_i,
  input  logic [DATA_W-1:0] dut_r_i,
  input  logic              trace_ack_i,
  output logic              trace_req_o,
  output logic [DATA_W-1:0] trace_o,
  output logic [CNT_W-1:0]  cpt_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              ovf_o,
  output logic [15:0]       ovf_cnt_o
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

  localparam logic [DEPTH_LOG2-1:0] PTR_ONE = 1;
  localparam logic [DEPTH_LOG2:0]   OCC_ONE = 1;
  localparam logic [CNT_W-1:0]      CNT_ONE = 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CAPT  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t state;

  logic [DATA_W-1:0]     mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic [DEPTH_LOG2:0]   occ;
  logic [CNT_W-1:0]      nb_lat;

  logic             fifo_full;
  logic             push_req;
  logic             push_ok;
  logic             pop;
  logic             drop;
  logic             sess_start;
  logic [CNT_W-1:0] cpt_inc;

  // Occupancy never exceeds DEPTH, so its MSB alone marks "full".
  assign fifo_full   = occ[DEPTH_LOG2];
  assign trace_req_o = (occ != '0);
  assign trace_o     = trace_req_o ? mem[rd_ptr] : '0;

  assign pop        = trace_req_o & trace_ack_i & ~stop_i;
  assign push_req   = (state == CAPT) & dut_dv_i & ~stop_i;
  // A simultaneous pop frees the slot, so a push into a full FIFO still lands.
  assign push_ok    = push_req & (~fifo_full | pop);
  // Results lost to a full FIFO or presented while frozen both count as overflow.
  assign drop       = (push_req & ~push_ok) | ((state == CAPT) & dut_dv_i & stop_i);
  assign sess_start = (state == IDLE) & run_i & ~stop_i;
  assign cpt_inc    = (cpt_o == '1) ? cpt_o : cpt_o + CNT_ONE;

  // FIFO storage: written on accepted pushes only, no reset needed.
  always_ff @(posedge clk_ref) begin
    if (push_ok) begin
      mem[wr_ptr] <= dut_r_i;
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk_ref or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      case ({push_ok, pop})
        2'b10:   occ <= occ + OCC_ONE;
        2'b01:   occ <= occ - OCC_ONE;
        default: occ <= occ;
      endcase
    end
  end

  // Session FSM with registered busy/done/overflow and result counter.
  always_ff @(posedge clk_ref or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      nb_lat <= '0;
      cpt_o  <= '0;
      busy_o <= 1'b0;
      done_o <= 1'b0;
      ovf_o  <= 1'b0;
    end else begin
      if (drop) begin
        ovf_o <= 1'b1;
      end
      if (!stop_i) begin
        case (state)
          IDLE: begin
            done_o <= 1'b0;
            if (run_i) begin
              nb_lat <= nb_trace_i;
              cpt_o  <= '0;
              ovf_o  <= 1'b0;
              if (nb_trace_i == '0) begin
                state  <= DONE;
                busy_o <= 1'b0;
                done_o <= 1'b1;
              end else begin
                state  <= CAPT;
                busy_o <= 1'b1;
              end
            end
          end
          CAPT: begin
            if (dut_dv_i) begin
              cpt_o <= cpt_inc;
              if (cpt_inc == nb_lat) begin
                state <= DRAIN;
              end
            end
          end
          DRAIN: begin
            if (occ == '0) begin
              state  <= DONE;
              busy_o <= 1'b0;
              done_o <= 1'b1;
            end
          end
          DONE: begin
            state  <= IDLE;
            done_o <= 1'b0;
          end
          default: begin
            state  <= IDLE;
            busy_o <= 1'b0;
            done_o <= 1'b0;
          end
        endcase
      end
    end
  end

`ifdef TRACE_OVF_CNT_EN
  // Saturating dropped-result counter, cleared on session start.
  always_ff @(posedge clk_ref or negedge rst_n) begin
    if (!rst_n) begin
      ovf_cnt_o <= '0;
    end else if (sess_start) begin
      ovf_cnt_o <= '0;
    end else if (drop && (ovf_cnt_o != '1)) begin
      ovf_cnt_o <= ovf_cnt_o + 16'd1;
    end
  end
`else
  logic unused_start;
  assign unused_start = sess_start;
  assign ovf_cnt_o    = '0;
`endif

endmodule

// File: tb/tb_a_mux_trace_64x64.sv
// Directed scoreboard bench for a_mux_trace_64x64.
module tb_a_mux_trace_64x64;

`ifdef TRACE_OVF_CNT_EN
  localparam int OVF_EN = 1;
`else
  localparam int OVF_EN = 0;
`endif

  logic        clk_ref = 1'b0;
  logic        rst_n;
  logic        run_i, stop_i, dut_dv_i, trace_ack_i;
  logic [15:0] nb_trace_i;
  logic [63:0] dut_r_i;
  logic        trace_req_o, busy_o, done_o, ovf_o;
  logic [63:0] trace_o;
  logic [15:0] cpt_o, ovf_cnt_o;

  a_mux_trace_64x64 #(.DATA_W(64), .DEPTH_LOG2(3), .CNT_W(16)) dut (
    .clk_ref     (clk_ref),
    .rst_n       (rst_n),
    .run_i       (run_i),
    .stop_i      (stop_i),
    .nb_trace_i  (nb_trace_i),
    .dut_dv_i    (dut_dv_i),
    .dut_r_i     (dut_r_i),
    .trace_ack_i (trace_ack_i),
    .trace_req_o (trace_req_o),
    .trace_o     (trace_o),
    .cpt_o       (cpt_o),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .ovf_o       (ovf_o),
    .ovf_cnt_o   (ovf_cnt_o)
  );

  always #5 clk_ref = ~clk_ref;

  typedef struct {
    logic [63:0] data;
    int          exp_cyc;  // -1: no latency check
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int xfer_cnt = 0;
  int done_cnt = 0;
  int req_seen = 0;

  always @(posedge clk_ref) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: a transfer is committed at the next rising edge whenever req&ack&!stop.
  always @(negedge clk_ref) begin : mon
    exp_t e;
    if (rst_n) begin
      if (done_o) done_cnt <= done_cnt + 1;
      if (trace_req_o) req_seen <= req_seen + 1;
      if (trace_req_o && trace_ack_i && !stop_i) begin
        xfer_cnt <= xfer_cnt + 1;
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL sb_unexpected: got 0x%0h expected no transfer", trace_o);
        end else begin
          e = sb.pop_front();
          chk("sb_data", trace_o, e.data);
          if (e.exp_cyc >= 0) chk("sb_latency", 64'(cyc), 64'(e.exp_cyc));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk_ref);
    #1;
  endtask

  task automatic start(input logic [15:0] nb);
    nb_trace_i = nb;
    run_i = 1'b1;
    tick();
    run_i = 1'b0;
  endtask

  // Present one result; 'acc' marks it as expected on the trace side.
  task automatic push(input logic [63:0] w, input bit acc, input bit lat);
    exp_t e;
    dut_dv_i = 1'b1;
    dut_r_i  = w;
    if (acc) begin
      e.data = w;
      e.exp_cyc = lat ? cyc + 1 : -1;
      sb.push_back(e);
    end
    tick();
    dut_dv_i = 1'b0;
  endtask

  task automatic wait_done(input string name, input int bound);
    bit seen = 0;
    for (int i = 0; i < bound; i++) begin
      if (done_o) begin
        seen = 1;
        break;
      end
      tick();
    end
    chk(name, 64'(seen), 64'd1);
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_req"},  64'(trace_req_o), 64'd0);
    chk({tag, "_data"}, trace_o, 64'd0);
    chk({tag, "_cpt"},  64'(cpt_o), 64'd0);
    chk({tag, "_busy"}, 64'(busy_o), 64'd0);
    chk({tag, "_done"}, 64'(done_o), 64'd0);
    chk({tag, "_ovf"},  64'(ovf_o), 64'd0);
    chk({tag, "_ovfc"}, 64'(ovf_cnt_o), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0, x0, r0;
    rst_n = 1'b0; run_i = 1'b0; stop_i = 1'b0; dut_dv_i = 1'b0;
    trace_ack_i = 1'b0; nb_trace_i = '0; dut_r_i = '0;
    repeat (3) tick();
    chk_reset_outs("rst");
    rst_n = 1'b1;
    tick();

    // 1: four words streamed with ack held high, one-cycle latency each
    d0 = done_cnt; x0 = xfer_cnt;
    trace_ack_i = 1'b1;
    start(16'd4);
    push(64'h11, 1, 1);
    push(64'h22, 1, 1);
    push(64'h33, 1, 1);
    push(64'h44, 1, 1);
    wait_done("t1_done", 20);
    chk("t1_cpt", 64'(cpt_o), 64'd4);
    chk("t1_ovf", 64'(ovf_o), 64'd0);
    repeat (3) tick();
    chk("t1_done_once", 64'(done_cnt - d0), 64'd1);
    chk("t1_xfers", 64'(xfer_cnt - x0), 64'd4);

    // 2: twelve results with ack low: eight kept, four dropped
    d0 = done_cnt; x0 = xfer_cnt;
    trace_ack_i = 1'b0;
    start(16'd12);
    for (int i = 1; i <= 12; i++) push(64'h2000 + 64'(i), i <= 8, 0);
    chk("t2_ovf", 64'(ovf_o), 64'd1);
    chk("t2_ovfcnt", 64'(ovf_cnt_o), OVF_EN ? 64'd4 : 64'd0);
    chk("t2_cpt", 64'(cpt_o), 64'd12);
    chk("t2_head", trace_o, 64'h2001);
    chk("t2_busy", 64'(busy_o), 64'd1);
    push(64'h2DEAD, 0, 0);  // in DRAIN: ignored entirely
    chk("t2_drain_cpt", 64'(cpt_o), 64'd12);
    chk("t2_drain_ovfcnt", 64'(ovf_cnt_o), OVF_EN ? 64'd4 : 64'd0);
    trace_ack_i = 1'b1;
    wait_done("t2_done", 40);
    repeat (3) tick();
    chk("t2_xfers", 64'(xfer_cnt - x0), 64'd8);
    chk("t2_done_once", 64'(done_cnt - d0), 64'd1);

    // 3: full FIFO with push and pop in the same cycle
    d0 = done_cnt; x0 = xfer_cnt;
    trace_ack_i = 1'b0;
    start(16'd9);
    for (int i = 1; i <= 8; i++) push(64'h3000 + 64'(i), 1, 0);
    trace_ack_i = 1'b1;
    push(64'h3009, 1, 0);
    trace_ack_i = 1'b0;
    chk("t3_ovf", 64'(ovf_o), 64'd0);
    chk("t3_ovfcnt", 64'(ovf_cnt_o), 64'd0);
    chk("t3_cpt", 64'(cpt_o), 64'd9);
    chk("t3_head", trace_o, 64'h3002);
    trace_ack_i = 1'b1;
    wait_done("t3_done", 40);
    repeat (2) tick();
    chk("t3_xfers", 64'(xfer_cnt - x0), 64'd9);

    // 4: stop freezes the handshake; a result during stop is an overflow
    x0 = xfer_cnt;
    trace_ack_i = 1'b0;
    start(16'd3);
    push(64'h4001, 1, 0);
    stop_i = 1'b1; trace_ack_i = 1'b1; dut_dv_i = 1'b1; dut_r_i = 64'h4BAD;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t4_hold_data", trace_o, 64'h4001);
      chk("t4_hold_req", 64'(trace_req_o), 64'd1);
      chk("t4_hold_cpt", 64'(cpt_o), 64'd1);
    end
    stop_i = 1'b0; dut_dv_i = 1'b0;
    chk("t4_ovf", 64'(ovf_o), 64'd1);
    chk("t4_ovfcnt", 64'(ovf_cnt_o), OVF_EN ? 64'd3 : 64'd0);
    chk("t4_xfers_frozen", 64'(xfer_cnt - x0), 64'd0);
    push(64'h4002, 1, 0);
    push(64'h4003, 1, 0);
    wait_done("t4_done", 20);
    chk("t4_cpt", 64'(cpt_o), 64'd3);
    repeat (2) tick();
    chk("t4_xfers", 64'(xfer_cnt - x0), 64'd3);

    // 5: empty session ends immediately
    d0 = done_cnt; r0 = req_seen;
    trace_ack_i = 1'b0;
    start(16'd0);
    chk("t5_done_hi", 64'(done_o), 64'd1);
    chk("t5_busy", 64'(busy_o), 64'd0);
    tick();
    chk("t5_done_lo", 64'(done_o), 64'd0);
    repeat (3) tick();
    chk("t5_done_once", 64'(done_cnt - d0), 64'd1);
    chk("t5_no_req", 64'(req_seen - r0), 64'd0);

    // 6: asynchronous reset in DRAIN with five words queued
    start(16'd5);
    for (int i = 1; i <= 5; i++) push(64'h6000 + 64'(i), 0, 0);
    tick();
    chk("t6_busy", 64'(busy_o), 64'd1);
    chk("t6_req", 64'(trace_req_o), 64'd1);
    chk("t6_cpt", 64'(cpt_o), 64'd5);
    #2 rst_n = 1'b0;
    #1 chk_reset_outs("t6rst");
    tick();
    #2 rst_n = 1'b1;
    tick();
    chk("t6_req_after", 64'(trace_req_o), 64'd0);
    chk("t6_busy_after", 64'(busy_o), 64'd0);
    x0 = xfer_cnt;
    trace_ack_i = 1'b1;
    start(16'd1);
    chk("t6_idle_run", 64'(busy_o), 64'd1);
    push(64'h6ABC, 1, 1);
    wait_done("t6_done", 20);
    chk("t6_cpt_new", 64'(cpt_o), 64'd1);
    repeat (2) tick();
    chk("t6_xfers", 64'(xfer_cnt - x0), 64'd1);

    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
